cnn_layer_accel_result_packer: RTL

CNN_LAYER_ACCEL_RESULT_PACKER -- requirements
Module: cnn_layer_accel_result_packer

---
 rtl/cnn_layer_accel_result_packer.sv | 101 ++++++++++
 1 files changed

// File: rtl/cnn_layer_accel_result_packer.sv
// cnn_layer_accel_result_packer: packs 16-bit convolution results into 128-bit words with keep/last framing
module cnn_layer_accel_result_packer #(
  parameter int C_LANES = 8,
  parameter int C_DIM_W = 10
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   job_start,
  input  logic [C_DIM_W-1:0]     num_output_rows,
  input  logic [C_DIM_W-1:0]     num_output_cols,
  input  logic [C_DIM_W-1:0]     num_kernels,
  input  logic                   result_valid,
  output logic                   result_accept,
  input  logic [15:0]            result_data,
  output logic                   pack_valid,
  input  logic                   pack_ready,
  output logic [16*C_LANES-1:0]  pack_data,
  output logic [C_LANES-1:0]     pack_keep,
  output logic                   pack_last,
  output logic                   busy,
  output logic                   job_done
);
  localparam int TW = 3*C_DIM_W;
  localparam int LW = $clog2(C_LANES);
  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;
  state_t                 state;
  logic [TW-1:0]          total, res_cnt, job_total;
  logic [LW-1:0]          lane_cnt;
  logic [16*C_LANES-1:0]  acc, acc_nx;
  logic [C_LANES-1:0]     keep_acc, keep_nx;
  logic                   take, final_res, word_done;
  assign job_total     = TW'(num_output_rows) * TW'(num_output_cols) * TW'(num_kernels);
  assign result_accept = (state == COLLECT) && (!pack_valid || pack_ready);
  assign take          = result_accept && result_valid;
  assign final_res     = res_cnt == total - TW'(1);
  assign word_done     = take && (lane_cnt == LW'(C_LANES-1) || final_res);
  // accumulator image with the incoming result merged into the current lane
  always_comb begin
    acc_nx = acc;
    acc_nx[{lane_cnt, 4'b0000} +: 16] = result_data;
    keep_nx = keep_acc | (C_LANES'(1) << lane_cnt);
  end
  // job sequencing: config latch, result/lane counters, busy and done pulse
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      total    <= '0;
      res_cnt  <= '0;
      lane_cnt <= '0;
      busy     <= 1'b0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      if (take) begin
        res_cnt  <= res_cnt + TW'(1);
        lane_cnt <= lane_cnt + LW'(1);
      end
      case (state)
        IDLE: if (job_start) begin
          total    <= job_total;
          res_cnt  <= '0;
          lane_cnt <= '0;
          state    <= job_total == '0 ? DONE : COLLECT;
          busy     <= job_total != '0;
          job_done <= job_total == '0;
        end
        COLLECT: if (take && final_res) state <= FLUSH;
        FLUSH: if (pack_valid && pack_ready) begin
          state    <= DONE;
          busy     <= 1'b0;
          job_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // lane accumulation and the output holding register with valid/ready handshake
  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      keep_acc   <= '0;
      pack_valid <= 1'b0;
      pack_data  <= '0;
      pack_keep  <= '0;
      pack_last  <= 1'b0;
    end else begin
      if (take) begin
        acc      <= word_done ? '0 : acc_nx;
        keep_acc <= word_done ? '0 : keep_nx;
      end
      if (word_done) begin
        pack_valid <= 1'b1;
        pack_data  <= acc_nx;
        pack_keep  <= keep_nx;
        pack_last  <= final_res;
      end else if (pack_ready) begin
        pack_valid <= 1'b0;
      end
    end
  end
endmodule
